// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by the sequential ALU files.
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  typedef enum logic {ST_IDLE, ST_MUL_BUSY} state_t;
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, low WIDTH bits, done WIDTH-1 cycles after start.
module alu_seq_mul #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, step;
  logic [CW-1:0] cnt_q;
  logic busy_q;
  // The last partial product is folded in combinationally so the caller can
  // register the product on the WIDTH-th edge after start.
  assign step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product_o = step;
  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      cnt_q    <= '0;
    end else if (busy_q) begin
      busy_q   <= !done_o;
      acc_q    <= step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq_param.sv
// alu_seq_param: registered ALU with valid/ready on both sides, N/Z/C/V flags and an iterative MUL.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);
  localparam int SHAMT_W = $clog2(WIDTH);
  state_t state_q, state_d;
  logic out_valid_q, zero_q, neg_q, carry_q, ovf_q;
  logic [WIDTH-1:0] result_q, res_d, mul_p, ld_res;
  logic [WIDTH:0] sum, diff;
  logic [SHAMT_W-1:0] sh;
  logic accept, is_mul, mul_done, mul_busy, c_d, v_d, ld;
  assign in_ready = (state_q == ST_IDLE) && !mul_busy && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_ENABLE && (control == ALU_MUL);
  assign sh       = b[SHAMT_W-1:0];
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (control)
      ALU_AND: res_d = a & b;
      ALU_OR:  res_d = a | b;
      ALU_NOR: res_d = ~(a | b);
      ALU_XOR: res_d = a ^ b;
      ALU_ADD: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        res_d = diff[WIDTH-1:0];
        c_d   = diff[WIDTH];
        v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: res_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLL: res_d = a << sh;
      ALU_SRL: res_d = a >> sh;
      ALU_SRA: res_d = $signed(a) >>> sh;
      default: res_d = '0;
    endcase
  end
  always_comb state_d = (accept && is_mul) ? ST_MUL_BUSY : mul_done ? ST_IDLE : state_q;
  assign ld     = (accept && !is_mul) || mul_done;
  assign ld_res = mul_done ? mul_p : res_d;
  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (accept && is_mul),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_p)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ld) begin
        out_valid_q <= 1'b1;
        result_q    <= ld_res;
        zero_q      <= (ld_res == '0);
        neg_q       <= ld_res[WIDTH-1];
        carry_q     <= !mul_done && c_d;
        ovf_q       <= !mul_done && v_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: directed vectors into a scoreboard queue, checked by a monitor on output handshakes.
module tb_alu_seq_param;
  localparam int W = 64;
  localparam logic [W-1:0] ONES = '1;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0] control = '0;
  logic in_ready, out_valid, zero, negative, carry, overflow;
  logic [W-1:0] result;
  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
    string        nm;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, stalls = 0;

  alu_seq_param #(.WIDTH(W), .MUL_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .control(control), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // flags packed as {zero, negative, carry, overflow}
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got result=%h flags=%b, none expected", result,
                 {zero, negative, carry, overflow});
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({result, zero, negative, carry, overflow} !== {e.r, e.f}) begin
          fails++;
          $display("FAIL %s: got result=%h flags=%b, want result=%h flags=%b", e.nm, result,
                   {zero, negative, carry, overflow}, e.r, e.f);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input string nm, input logic [3:0] op, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] r, input logic [3:0] f);
    int n;
    control  = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    stalls += n;
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s_accept_timeout: in_ready=%b after %0d cycles, want 1", nm, in_ready, n);
    end
    sb.push_back('{r, f, nm});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid_flags", W'({out_valid, zero, negative, carry, overflow}), '0);
    chk("reset_result", result, '0);
    reset = 1'b0;
    #1;
    chk("reset_in_ready", W'(in_ready), 1);

    stalls = 0;
    send("and", 4'b0000, 30, 20, 20, 4'b0000);
    send("or",  4'b0001, 30, 20, 30, 4'b0000);
    send("nor", 4'b1100, 30, 20, 64'hFFFF_FFFF_FFFF_FFE1, 4'b0100);
    send("add", 4'b0010, 30, 20, 50, 4'b0000);
    chk("b2b_stall_cycles", W'(stalls), 0);

    send("sub_eq",   4'b0110, 20, 20, 0, 4'b1010);
    send("sub_neg",  4'b0110, 1, 2, ONES, 4'b0100);
    send("add_ovf",  4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 1, 64'h8000_0000_0000_0000, 4'b0101);
    send("add_wrap", 4'b0010, ONES, 1, 0, 4'b1010);

    control  = 4'b1000;
    a        = 30;
    b        = 20;
    in_valid = 1'b1;
    chk("mul_in_ready", W'(in_ready), 1);
    sb.push_back('{W'(600), 4'b0000, "mul_30x20"});
    @(posedge clk); #1;
    in_valid = 1'b0;
    bad = 0;
    for (int j = 0; j < 64; j++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("mul_busy_cycles_bad", W'(bad), 0);
    chk("mul_latency_out_valid", W'(out_valid), 1);

    send("mul_ones", 4'b1000, ONES, ONES, 1, 4'b0000);
    send("mul_zero", 4'b1000, 0, 5, 0, 4'b1000);
    drain();

    out_ready = 1'b0;
    send("hold_add", 4'b0010, 5, 7, 12, 4'b0000);
    control  = 4'b0110;
    a        = 9;
    b        = 4;
    in_valid = 1'b1;
    bad = 0;
    for (int j = 0; j < 5; j++) begin
      if (result !== 12 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("hold_cycles_bad", W'(bad), 0);
    out_ready = 1'b1;
    sb.push_back('{W'(5), 4'b0010, "hold_sub"});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold_next_result", result, 5);
    chk("hold_next_valid", W'(out_valid), 1);
    drain();

    control  = 4'b1000;
    a        = 30;
    b        = 20;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midmul_reset_state", W'({out_valid, zero, negative, carry, overflow}), '0);
    chk("midmul_reset_result", result, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midmul_release_in_ready", W'(in_ready), 1);
    repeat (70) @(posedge clk);
    #1;
    chk("midmul_no_result", W'(out_valid), 0);
    send("post_reset_add", 4'b0010, 3, 4, 7, 4'b0000);

    send("illegal",  4'b1111, 5, 6, 0, 4'b1000);
    send("sra_63",   4'b0101, 64'h8000_0000_0000_0000, 63, ONES, 4'b0100);
    send("srl_63",   4'b0100, 64'h8000_0000_0000_0000, 63, 1, 4'b0000);
    send("sll_wrap", 4'b0011, 1, 68, 16, 4'b0000);
    send("sll_zero", 4'b0011, 64'h1234, 0, 64'h1234, 4'b0000);
    send("xor",      4'b1001, 64'hF0, 64'hFF, 64'h0F, 4'b0000);
    send("slt_true", 4'b0111, ONES, 1, 1, 4'b0000);
    send("slt_false", 4'b0111, 1, ONES, 0, 4'b1000);
    drain();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
